// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared counter width, bar colours and pattern encodings
package video_timing_pkg;
  localparam int CNT_W = 12;
  localparam logic [23:0] C_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] C_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] C_CYAN    = 24'h00FFFF;
  localparam logic [23:0] C_GREEN   = 24'h00FF00;
  localparam logic [23:0] C_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] C_RED     = 24'hFF0000;
  localparam logic [23:0] C_BLUE    = 24'h0000FF;
  localparam logic [23:0] C_BLACK   = 24'h000000;
  localparam logic [23:0] C_GREY    = 24'h808080;
  localparam logic [7:0][23:0] BAR_COLOURS = {C_BLACK, C_BLUE, C_RED, C_MAGENTA,
                                              C_GREEN, C_CYAN, C_YELLOW, C_WHITE};
  typedef enum logic [1:0] {
    PAT_BARS = 2'b00,
    PAT_GRAD = 2'b01,
    PAT_GRID = 2'b10,
    PAT_GREY = 2'b11
  } pat_sel_e;
endpackage

// File: rtl/video_timing_gen_pattern.sv
// pattern_gen: combinational test-pattern colour for the current raster position
module pattern_gen
  import video_timing_pkg::*;
(
  input  pat_sel_e    pat_sel,
  input  logic [7:0]  hcnt,
  input  logic [7:0]  vcnt,
  input  logic [2:0]  bar_idx,
  output logic [23:0] rgb
);
  logic grid_on;
  assign grid_on = (hcnt[4:0] == 5'd0) || (vcnt[4:0] == 5'd0);
  assign rgb = pat_sel == PAT_BARS ? BAR_COLOURS[bar_idx] :
               pat_sel == PAT_GRAD ? {hcnt, vcnt, hcnt ^ vcnt} :
               pat_sel == PAT_GRID ? (grid_on ? C_WHITE : C_BLACK) :
               C_GREY;
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, sync/DE decode and registered pattern output
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
)(
  input  logic       Clk,
  input  logic       RstB,
  input  logic       Enable,
  input  logic [1:0] PatSel,
  output logic       DE,
  output logic       HSync,
  output logic       VSync,
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       FrameStart
);
  localparam logic [CNT_W-1:0] H_ACT   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS    = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_ACT   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SS    = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] BAR_END = CNT_W'(H_ACTIVE / 8 - 1);

  logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, bar_cnt_q, bar_cnt_d;
  logic [2:0]       bar_idx_q, bar_idx_d;
  pat_sel_e         pat_q, pat_d;
  logic             de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [23:0]      rgb_q, rgb_d, pat_rgb;
  logic             h_wrap, v_wrap, bar_wrap;

  pattern_gen u_pattern (
    .pat_sel (pat_q),
    .hcnt    (hcnt_q[7:0]),
    .vcnt    (vcnt_q[7:0]),
    .bar_idx (bar_idx_q),
    .rgb     (pat_rgb)
  );

  // raster and bar counters; Enable low parks everything at the origin, PatSel latched at frame wrap
  always_comb begin
    h_wrap    = hcnt_q == H_END;
    v_wrap    = vcnt_q == V_END;
    bar_wrap  = bar_cnt_q == BAR_END;
    hcnt_d    = !Enable || h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d    = !Enable ? '0 : h_wrap ? (v_wrap ? '0 : vcnt_q + 1'b1) : vcnt_q;
    bar_cnt_d = !Enable || h_wrap || bar_wrap ? '0 : bar_cnt_q + 1'b1;
    bar_idx_d = !Enable || h_wrap ? '0 : bar_wrap ? bar_idx_q + 1'b1 : bar_idx_q;
    pat_d     = Enable && h_wrap && v_wrap ? pat_sel_e'(PatSel) : pat_q;
  end

  // decode of the current position, registered below so every output shares one cycle of latency
  always_comb begin
    de_d  = Enable && hcnt_q < H_ACT && vcnt_q < V_ACT;
    fs_d  = Enable && hcnt_q == '0 && vcnt_q == '0;
    hs_d  = Enable && hcnt_q >= H_SS && hcnt_q < H_SE ? H_POL : !H_POL;
    vs_d  = Enable && vcnt_q >= V_SS && vcnt_q < V_SE ? V_POL : !V_POL;
    rgb_d = de_d ? pat_rgb : '0;
  end

  // state and output registers with asynchronous reset to the blank, sync-inactive state
  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      pat_q     <= PAT_BARS;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      hs_q      <= !H_POL;
      vs_q      <= !V_POL;
      rgb_q     <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      pat_q     <= pat_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rgb_q     <= rgb_d;
    end
  end

  assign DE         = de_q;
  assign FrameStart = fs_q;
  assign HSync      = hs_q;
  assign VSync      = vs_q;
  assign {Red, Green, Blue} = rgb_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for the small-raster configuration
module tb_video_timing_gen;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3, VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;

  logic       Clk = 1'b0, RstB = 1'b0, Enable = 1'b1;
  logic [1:0] PatSel = 2'b00;
  logic       DE, HSync, VSync, FrameStart;
  logic [7:0] Red, Green, Blue;

  int          errors = 0, checks = 0;
  logic [27:0] exp_q[$];
  logic [27:0] mon_e, mon_a;
  int          mx = 0, my = 0;
  logic [1:0]  mpat = 2'b00;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  event        chk_now;
  logic        fs_seen;

  always #5 Clk = ~Clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b1), .V_POL(1'b1)
  ) dut (
    .Clk(Clk), .RstB(RstB), .Enable(Enable), .PatSel(PatSel),
    .DE(DE), .HSync(HSync), .VSync(VSync),
    .Red(Red), .Green(Green), .Blue(Blue), .FrameStart(FrameStart)
  );

  function automatic logic [27:0] expect_out(input int x, input int y, input logic [1:0] p, input logic en);
    logic de, hs, vs, fs;
    logic [23:0] c;
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    de = en && x < HA && y < VA;
    hs = en && x >= HA + HF && x < HA + HF + HS;
    vs = en && y >= VA + VF && y < VA + VF + VS;
    fs = en && x == 0 && y == 0;
    c = 24'h0;
    if (de)
      case (p)
        2'd0: c = bars[x / (HA / 8)];
        2'd1: c = {xb, yb, xb ^ yb};
        2'd2: c = (x % 32 == 0 || y % 32 == 0) ? 24'hFFFFFF : 24'h0;
        default: c = 24'h808080;
      endcase
    return {de, hs, vs, fs, c};
  endfunction

  task automatic step(input logic en, input logic [1:0] ps);
    @(negedge Clk);
    Enable = en;
    PatSel = ps;
    exp_q.push_back(expect_out(mx, my, mpat, en));
    if (!en) begin
      mx = 0;
      my = 0;
    end else begin
      if (mx == HT - 1 && my == VT - 1) mpat = ps;
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else mx++;
    end
  endtask

  initial forever begin
    @(posedge Clk or chk_now);
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {DE, HSync, VSync, FrameStart, Red, Green, Blue};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL outputs t=%0t {de,hs,vs,fs,rgb} got %h want %h", $time, mon_a, mon_e);
      end
    end
  end

  initial begin
    #1;
    checks++;
    if ({DE, HSync, VSync, FrameStart, Red, Green, Blue} !== 28'h0) begin
      errors++;
      $display("FAIL reset state at start got %h", {DE, HSync, VSync, FrameStart, Red, Green, Blue});
    end
    exp_q.push_back(28'h0);
    ->chk_now;
    @(posedge Clk);
    #1 RstB = 1'b1;
    for (int f = 0; f < 4; f++)
      for (int c = 0; c < HT * VT; c++)
        step(1'b1, 2'(c < 50 ? f : (f == 3 ? 3 : f + 1)));
    while (!(mx == 10 && my == 2)) step(1'b1, 2'd3);
    repeat (5) step(1'b0, 2'd3);
    repeat (HT * VT + 30) step(1'b1, 2'd3);
    while (!(mx == 6 && my == 1)) step(1'b1, 2'd3);
    @(posedge Clk);
    #3 RstB = 1'b0;
    #1;
    checks++;
    if ({DE, HSync, VSync, FrameStart, Red, Green, Blue} !== 28'h0) begin
      errors++;
      $display("FAIL async reset mid-line got %h", {DE, HSync, VSync, FrameStart, Red, Green, Blue});
    end
    exp_q.push_back(28'h0);
    ->chk_now;
    @(posedge Clk);
    #3 RstB = 1'b1;
    mx = 0;
    my = 0;
    mpat = 2'b00;
    repeat (2 * HT * VT) step(1'b1, 2'd3);
    @(posedge Clk);
    #3;
    fs_seen = 1'b0;
    for (int i = 0; i < HT * VT + 4 && !fs_seen; i++) begin
      @(posedge Clk);
      #1 fs_seen = FrameStart;
    end
    checks++;
    if (!fs_seen) begin
      errors++;
      $display("FAIL timeout waiting for FrameStart");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
